// File: rtl/ctrl_alu_pipe.sv
// ----------------------------------------------------------------------------
// ctrl_alu_pipe
//   Pipelined control ALU for the EXEC stage. Resolves jumps and branches
//   (link value, next PC, direction, mispredict) in the first stage. The
//   remaining STAGES-1 stages only delay the result. A valid/ready handshake
//   lets empty stages fill while a later stage stalls. A mispredicting op
//   raises a one-cycle fetch redirect when it first reaches the output
//   stage, and it bumps a saturating mispredict counter.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   valid_i / ready_o   op handshake from the control-issue queue
//   tag_i, opcode_i     instruction tag and opcode
//   data1_i, data2_i    source operands
//   immd_i              branch offset in words
//   pc_i                instruction PC
//   predictedTarget_i   predicted target (jump target field in low bits)
//   predictedDir_i      predicted branch direction
//   flush_i             squash every in-flight op
//   valid_o / ready_i   result handshake to writeback / branch recovery
//   tag_o, result_o     result tag and link value
//   nextPC_o            resolved next PC
//   direction_o         resolved direction
//   flags_o             [7] executed [6] link [5] conditional [4] indirect
//                       [3] illegal [2:1] zero [0] mispredict
//   redirect_o          one-cycle mispredict pulse
//   redirectPC_o        fetch redirect target (held between pulses)
//   mispredCnt_o        saturating mispredict count
// ----------------------------------------------------------------------------

`ifndef SIZE_OPCODE_I
`define SIZE_OPCODE_I 6
`endif
`ifndef JUMP
`define JUMP 6'h02
`endif
`ifndef JAL
`define JAL 6'h03
`endif
`ifndef BEQ
`define BEQ 6'h04
`endif
`ifndef BNE
`define BNE 6'h05
`endif
`ifndef BLEZ
`define BLEZ 6'h06
`endif
`ifndef BGTZ
`define BGTZ 6'h07
`endif
`ifndef JR
`define JR 6'h08
`endif
`ifndef JALR
`define JALR 6'h09
`endif
`ifndef BLTZ
`define BLTZ 6'h0A
`endif
`ifndef BGEZ
`define BGEZ 6'h0B
`endif

module ctrl_alu_pipe #(
  parameter int PC_WIDTH     = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int IMM_WIDTH    = 16,
  parameter int TARGET_WIDTH = 26,
  parameter int STAGES       = 2,
  parameter int TAG_WIDTH    = 6,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [TAG_WIDTH-1:0]      tag_i,
  input  logic [`SIZE_OPCODE_I-1:0] opcode_i,
  input  logic [DATA_WIDTH-1:0]     data1_i,
  input  logic [DATA_WIDTH-1:0]     data2_i,
  input  logic [IMM_WIDTH-1:0]      immd_i,
  input  logic [PC_WIDTH-1:0]       pc_i,
  input  logic [PC_WIDTH-1:0]       predictedTarget_i,
  input  logic                      predictedDir_i,
  input  logic                      flush_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [TAG_WIDTH-1:0]      tag_o,
  output logic [PC_WIDTH-1:0]       result_o,
  output logic [PC_WIDTH-1:0]       nextPC_o,
  output logic                      direction_o,
  output logic [7:0]                flags_o,
  output logic                      redirect_o,
  output logic [PC_WIDTH-1:0]       redirectPC_o,
  output logic [CNT_WIDTH-1:0]      mispredCnt_o
);

  // Everything one op carries down the pipe after evaluation.
  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [PC_WIDTH-1:0]  result;
    logic [PC_WIDTH-1:0]  next_pc;
    logic                 direction;
    logic [7:0]           flags;
  } stage_t;

  // --------------------------------------------------------------------------
  // Evaluation (combinational, captured by stage 0)
  // --------------------------------------------------------------------------
  logic [PC_WIDTH-1:0] sign_ex;
  logic [PC_WIDTH-1:0] link_pc;
  logic [PC_WIDTH-1:0] jump_pc;
  logic [PC_WIDTH-1:0] branch_pc;
  logic                is_neg;
  logic                is_zero;
  logic                taken;
  stage_t              ev;

  always_comb begin
    // NOTE: every variable gets a default before the case statements, so
    // no path leaves a value unassigned and no latch is inferred.
    sign_ex   = {{(PC_WIDTH-IMM_WIDTH){immd_i[IMM_WIDTH-1]}}, immd_i} << 2;
    link_pc   = pc_i + PC_WIDTH'(8);
    jump_pc   = {pc_i[PC_WIDTH-1:TARGET_WIDTH+2],
                 predictedTarget_i[TARGET_WIDTH-1:0], 2'b00};
    branch_pc = link_pc + sign_ex;
    is_neg    = data1_i[DATA_WIDTH-1];
    is_zero   = (data1_i == '0);

    taken = 1'b0;
    case (opcode_i)
      `BEQ:    taken = (data1_i == data2_i);
      `BNE:    taken = (data1_i != data2_i);
      `BLEZ:   taken = is_neg || is_zero;
      `BGTZ:   taken = !is_neg && !is_zero;
      `BLTZ:   taken = is_neg;
      `BGEZ:   taken = !is_neg;
      default: taken = 1'b0;
    endcase

    ev          = '0;
    ev.tag      = tag_i;
    ev.flags[7] = 1'b1;
    case (opcode_i)
      `JUMP: begin
        ev.next_pc   = jump_pc;
        ev.direction = 1'b1;
      end
      `JAL: begin
        ev.next_pc   = jump_pc;
        ev.direction = 1'b1;
        ev.result    = link_pc;
        ev.flags[6]  = 1'b1;
      end
      `JR: begin
        ev.next_pc   = data1_i;
        ev.direction = 1'b1;
        ev.flags[4]  = 1'b1;
        ev.flags[0]  = (data1_i != predictedTarget_i);
      end
      `JALR: begin
        ev.next_pc   = data1_i;
        ev.direction = 1'b1;
        ev.result    = link_pc;
        ev.flags[6]  = 1'b1;
        ev.flags[4]  = 1'b1;
        ev.flags[0]  = (data1_i != predictedTarget_i);
      end
      `BEQ, `BNE, `BLEZ, `BGTZ, `BLTZ, `BGEZ: begin
        ev.next_pc   = taken ? branch_pc : link_pc;
        ev.direction = taken;
        ev.flags[5]  = 1'b1;
        // A taken branch still mispredicts if fetch went somewhere else.
        ev.flags[0]  = (taken != predictedDir_i) ||
                       (taken && (branch_pc != predictedTarget_i));
      end
      default: ev.flags[3] = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline control
  // --------------------------------------------------------------------------
  logic [STAGES-1:0] v_q;
  stage_t            d_q  [STAGES];
  logic [STAGES-1:0] in_v;
  stage_t            in_d [STAGES];
  logic [STAGES-1:0] hold;
  logic              stall;

  logic                 redirect_q;
  logic [PC_WIDTH-1:0]  redirect_pc_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign stall = v_q[STAGES-1] && !ready_i;

  // A stage holds only if it is occupied and everything after it is blocked;
  // an empty stage keeps accepting, so bubbles squeeze out during a stall.
  always_comb begin : hold_chain
    logic h;
    h    = stall;
    hold = '0;
    hold[STAGES-1] = h;
    for (int k = STAGES - 2; k >= 0; k--) begin
      h       = v_q[k] && h;
      hold[k] = h;
    end
  end

  always_comb begin
    in_v[0] = valid_i;
    in_d[0] = ev;
    for (int k = 1; k < STAGES; k++) begin
      in_v[k] = v_q[k-1];
      in_d[k] = d_q[k-1];
    end
  end

  assign ready_o = !hold[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the payload registers are reset along with the valids because
      // every data output must read zero straight out of reset.
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) d_q[k] <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      cnt_q         <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so each stage samples the
      // previous stage's value from before this edge.
      redirect_q <= 1'b0;
      if (flush_i) begin
        v_q <= '0;
      end else begin
        for (int k = 0; k < STAGES; k++) begin
          if (!hold[k]) begin
            v_q[k] <= in_v[k];
            d_q[k] <= in_d[k];
          end
        end
        // Fire only on the edge a mispredicting op enters the output stage,
        // so a stalled op cannot pulse twice.
        if (!hold[STAGES-1] && in_v[STAGES-1] && in_d[STAGES-1].flags[0]) begin
          redirect_q    <= 1'b1;
          redirect_pc_q <= in_d[STAGES-1].next_pc;
          if (cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign valid_o      = v_q[STAGES-1];
  assign tag_o        = d_q[STAGES-1].tag;
  assign result_o     = d_q[STAGES-1].result;
  assign nextPC_o     = d_q[STAGES-1].next_pc;
  assign direction_o  = d_q[STAGES-1].direction;
  assign flags_o      = d_q[STAGES-1].flags;
  assign redirect_o   = redirect_q;
  assign redirectPC_o = redirect_pc_q;
  assign mispredCnt_o = cnt_q;

endmodule

// File: doc/ctrl_alu_pipe.md
Name: ctrl_alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle control ALU in the EXEC stage.
- Resolves jumps and branches: link result, next PC, direction, mispredict.
- Adds a valid/ready handshake, configurable latency, a one-shot redirect pulse on mispredict, flush/squash, and a saturating mispredict counter.
- Sits between the control-issue queue and writeback/branch-recovery logic.

Parameters:
- PC_WIDTH, 32, width of PC, target, result and nextPC.
- DATA_WIDTH, 32, operand width; must equal PC_WIDTH.
- IMM_WIDTH, 16, branch immediate width.
- TARGET_WIDTH, 26, jump target field width; TARGET_WIDTH+2 < PC_WIDTH.
- STAGES, 2, pipeline latency in cycles; legal values 1..4.
- TAG_WIDTH, 6, width of the instruction tag carried alongside each op.
- CNT_WIDTH, 16, mispredict counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- valid_i  in  1  input op valid.
- ready_o  out  1  block can accept an op this cycle.
- tag_i  in  TAG_WIDTH  instruction tag.
- opcode_i  in  `SIZE_OPCODE_I  opcode (codebase `JUMP/`JAL/`JR/`JALR/`BEQ/`BNE/`BLEZ/`BGTZ/`BLTZ/`BGEZ encodings).
- data1_i, data2_i  in  DATA_WIDTH  source operands.
- immd_i  in  IMM_WIDTH  branch offset in words.
- pc_i  in  PC_WIDTH  instruction PC.
- predictedTarget_i  in  PC_WIDTH  predicted target.
- predictedDir_i  in  1  predicted direction.
- flush_i  in  1  squash all in-flight ops.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- tag_o  out  TAG_WIDTH  tag of result.
- result_o  out  PC_WIDTH  link value.
- nextPC_o  out  PC_WIDTH  resolved next PC.
- direction_o  out  1  resolved direction.
- flags_o  out  8  [7] executed, [6] link write, [5] conditional, [4] indirect, [3] illegal opcode, [2:1] zero, [0] mispredict.
- redirect_o  out  1  one-cycle mispredict pulse.
- redirectPC_o  out  PC_WIDTH  fetch redirect target.
- mispredCnt_o  out  CNT_WIDTH  saturating mispredict count.

Behaviour:
- Reset (synchronous, high):
  - All stage valids clear.
  - valid_o=0, redirect_o=0, mispredCnt_o=0; all data outputs 0.
  - ready_o=1 on the cycle after reset deasserts.
- Handshake:
  - Op accepted when valid_i && ready_o.
  - Result is transferred when valid_o && ready_i.
  - ready_o = !(stage-1 valid && stall).
  - stall = valid_o && !ready_i.
  - Pipeline advances only when not stalled; bubbles compress: an empty stage accepts even while a later stage stalls.
  - While stalled, outputs stay stable.
- Latency: accepted op appears at valid_o exactly STAGES cycles later when no stall occurs. Full throughput is one op per cycle.
- Evaluation happens in stage 1, registered; later stages only delay.
  - sign_ex = sign-extend(immd_i) << 2, truncated to PC_WIDTH.
  - JUMP/JAL: nextPC = {pc_i[PC_WIDTH-1:TARGET_WIDTH+2], predictedTarget_i[TARGET_WIDTH-1:0], 2'b00}; mispredict=0; direction=1.
  - JR/JALR: nextPC = data1_i; mispredict = (data1_i != predictedTarget_i); direction=1; indirect=1.
  - JAL/JALR: result = pc_i+8; link=1. Otherwise result=0.
  - Branches: direction by comparison, with "negative" meaning bit DATA_WIDTH-1.
    - BEQ: equal. BNE: not equal.
    - BLEZ: negative or zero. BGTZ: non-negative and nonzero.
    - BLTZ: negative. BGEZ: non-negative.
    - nextPC = direction ? pc_i+8+sign_ex : pc_i+8, modulo 2^PC_WIDTH.
    - mispredict = (direction != predictedDir_i) || (direction && nextPC != predictedTarget_i).
  - Other opcodes: flags = 8'b1000_1000; other outputs 0; no redirect.
- Redirect:
  - redirect_o pulses exactly once, for a single cycle, when an op with mispredict=1 first reaches the output stage.
  - The pulse is not repeated during stall.
  - redirectPC_o = nextPC_o on that cycle; it holds its value otherwise.
- Counter: mispredCnt_o increments on each redirect pulse and saturates at all-ones.
- Flush:
  - flush_i clears all stage valids and suppresses any redirect in that cycle.
  - An op presented with valid_i the same cycle is dropped; ready_o=1 next cycle.
  - Flush has priority over stall and input acceptance. The counter is unaffected.
- Reset mid-operation discards all ops; no redirect is issued.

Test Plan:
- Reset, then JAL pc=0x00400000, predictedTarget[25:0]=0x0100000 -> after STAGES cycles: valid_o=1, result=0x00400008, nextPC=0x00400000, flags[6]=1, redirect_o=0.
- BEQ pc=0x00400000, data1=data2=5, immd=0x0004, predictedDir=0 -> nextPC=0x00400018, direction=1, flags[0]=1, one redirect pulse with redirectPC=0x00400018, mispredCnt=1.
- BLTZ data1=0x80000000, immd=0xFFFF, pc=0x00400010, predicted taken to 0x00400014 -> nextPC=0x00400014, no mispredict.
- Back-to-back 4 ops with ready_i low for 3 cycles -> no op lost or duplicated, outputs stable while stalled, a redirect for a stalled mispredicting op pulses once only.
- Mispredicting JR in flight, flush_i asserted one cycle before it reaches output -> valid_o stays 0, no redirect, counter unchanged.
- Force counter to all-ones via CNT_WIDTH=2 and 5 mispredicts -> mispredCnt_o=3 and holds.
